// File: rtl/spi_mem_bridge.sv
// Byte-wide CPU front end for the SPI memory controller: serialises requests
// into single SPI transactions and keeps a direct-mapped write-through read cache.
module spi_mem_bridge #(
  parameter int ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_hit,
  input  logic        flush,
  output logic        spi_start,
  output logic        spi_write,
  output logic [15:0] spi_address,
  output logic [7:0]  spi_wdata,
  input  logic        spi_done,
  input  logic [7:0]  spi_rdata
);
  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 16 - IDX;

  typedef enum logic [2:0] {IDLE, HIT_RSP, ISSUE, WAIT, MISS_RSP} state_t;
  state_t state_reg, state_next;

  logic [ENTRIES-1:0] valid_reg;
  logic [TAGW-1:0]    tag_mem  [ENTRIES];
  logic [7:0]         data_mem [ENTRIES];

  logic        write_reg;
  logic [15:0] addr_reg;
  logic [7:0]  wdata_reg;
  logic [7:0]  hit_data_reg;
  logic [7:0]  rdata_reg;

  logic [IDX-1:0] lookup_idx, reg_idx;
  logic           lookup_hit, reg_line_match;
  logic           accept, done_in_wait, fill_en, wupd_en;

  assign lookup_idx     = req_addr[IDX-1:0];
  assign reg_idx        = addr_reg[IDX-1:0];
  assign lookup_hit     = valid_reg[lookup_idx] && (tag_mem[lookup_idx] == req_addr[15:IDX]);
  assign reg_line_match = valid_reg[reg_idx] && (tag_mem[reg_idx] == addr_reg[15:IDX]);

  assign accept       = req_valid && req_ready;
  assign done_in_wait = (state_reg == WAIT) && spi_done;
  assign fill_en      = done_in_wait && !write_reg;
  assign wupd_en      = done_in_wait && write_reg && reg_line_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = 8'h00;
    rsp_hit    = 1'b0;
    spi_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (!req_write && lookup_hit) ? HIT_RSP : ISSUE;
      end
      HIT_RSP: begin
        rsp_valid  = 1'b1;
        rsp_rdata  = hit_data_reg;
        rsp_hit    = 1'b1;
        state_next = IDLE;
      end
      ISSUE: begin
        spi_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (spi_done) state_next = MISS_RSP;
      end
      MISS_RSP: begin
        rsp_valid  = 1'b1;
        rsp_rdata  = write_reg ? 8'h00 : rdata_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Flush wins over a coincident fill, so the line stays invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush)                              valid_reg[i] <= 1'b0;
        else if (fill_en && reg_idx == IDX'(i)) valid_reg[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[reg_idx]  <= addr_reg[15:IDX];
      data_mem[reg_idx] <= spi_rdata;
    end else if (wupd_en) begin
      data_mem[reg_idx] <= wdata_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg    <= 1'b0;
      addr_reg     <= 16'h0000;
      wdata_reg    <= 8'h00;
      hit_data_reg <= 8'h00;
      rdata_reg    <= 8'h00;
    end else begin
      if (accept) begin
        write_reg    <= req_write;
        addr_reg     <= req_addr;
        wdata_reg    <= req_wdata;
        hit_data_reg <= data_mem[lookup_idx];
      end
      if (done_in_wait) rdata_reg <= spi_rdata;
    end
  end

  assign spi_write   = write_reg;
  assign spi_address = addr_reg;
  assign spi_wdata   = wdata_reg;
endmodule

// File: tb/tb_spi_mem_bridge.sv
// Scoreboard bench for spi_mem_bridge: reference memory plus an address-level
// cache model predict every response and every SPI transaction.
module tb_spi_mem_bridge;
  localparam int ENTRIES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        rsp_valid, rsp_hit;
  logic [7:0]  rsp_rdata;
  logic        flush, flush_drv = 1'b0, flush_spi = 1'b0;
  logic        spi_start, spi_write;
  logic [15:0] spi_address;
  logic [7:0]  spi_wdata;
  logic        spi_done, done_model = 1'b0, done_stray = 1'b0;
  logic [7:0]  spi_rdata = 8'h0;

  assign flush    = flush_drv | flush_spi;
  assign spi_done = done_model | done_stray;

  spi_mem_bridge #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
    .flush(flush),
    .spi_start(spi_start), .spi_write(spi_write), .spi_address(spi_address),
    .spi_wdata(spi_wdata), .spi_done(spi_done), .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic hit; logic [7:0] data; int acc_cyc; } rsp_t;
  typedef struct { logic w; logic [15:0] addr; logic [7:0] wdata; int start_cyc; logic fl_done; } spi_t;

  rsp_t rsp_q[$];
  spi_t spi_q[$];
  logic [7:0]  ref_mem [0:65535];
  logic        line_v [ENTRIES];
  logic [15:0] line_a [ENTRIES];
  int total = 0, bad = 0;
  int done_cyc = 0, spi_starts = 0;
  logic spi_busy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_lines();
    for (int i = 0; i < ENTRIES; i++) line_v[i] = 1'b0;
  endtask

  // SPI controller model: serves ref_mem after a random delay
  initial begin
    spi_t cur;
    int cnt;
    cur = '{w: 1'b0, addr: 16'h0, wdata: 8'h0, start_cyc: 0, fl_done: 1'b0};
    cnt = 0;
    forever begin
      @(negedge clk);
      done_model = 1'b0;
      flush_spi  = 1'b0;
      spi_rdata  = 8'($urandom);
      if (!rst_n) begin
        spi_busy = 1'b0;
      end else if (spi_busy) begin
        check("spi_start_extra", spi_start, 0);
        check("spi_addr_stable", spi_address, cur.addr);
        check("spi_write_stable", spi_write, cur.w);
        if (cur.w) check("spi_wdata_stable", spi_wdata, cur.wdata);
        if (cnt == 0) begin
          if (cur.w) ref_mem[cur.addr] = cur.wdata;
          else       spi_rdata = ref_mem[cur.addr];
          done_model = 1'b1;
          flush_spi  = cur.fl_done;
          done_cyc   = cyc + 1;
          spi_busy   = 1'b0;
        end else begin
          cnt--;
        end
      end else if (spi_start) begin
        spi_starts++;
        if (spi_q.size() == 0) begin
          check("unexpected_spi_start", 1, 0);
        end else begin
          cur = spi_q.pop_front();
          check("spi_start_cycle", cyc, cur.start_cyc);
          check("spi_write", spi_write, cur.w);
          check("spi_address", spi_address, cur.addr);
          if (cur.w) check("spi_wdata", spi_wdata, cur.wdata);
          spi_busy = 1'b1;
          cnt = $urandom_range(1, 8);
        end
      end
    end
  end

  // Response monitor
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata, r.data);
          check("rsp_hit", rsp_hit, r.hit);
          check("rsp_latency", cyc, r.hit ? r.acc_cyc : done_cyc);
          check("ready_during_rsp", req_ready, 0);
          $display("rsp cyc=%0d data=%h hit=%0d", cyc, rsp_rdata, rsp_hit);
        end
      end
    end
  end

  task automatic issue_req(input logic w, input logic [15:0] a, input logic [7:0] d,
                           input logic fa, input logic fd);
    rsp_t r;
    spi_t s;
    int idx, n;
    logic hit, fd_eff;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", req_ready, 1);
    idx    = int'(a) % ENTRIES;
    hit    = !w && line_v[idx] && (line_a[idx] == a);
    fd_eff = fd && !hit;
    r.hit = hit;
    r.data = w ? 8'h00 : ref_mem[a];
    r.acc_cyc = cyc + 1;
    rsp_q.push_back(r);
    if (!hit) begin
      s.w = w; s.addr = a; s.wdata = d; s.start_cyc = cyc + 1; s.fl_done = fd_eff;
      spi_q.push_back(s);
    end
    if (fa || fd_eff) clear_lines();
    if (!w && !hit && !fd_eff) begin
      line_v[idx] = 1'b1;
      line_a[idx] = a;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; flush_drv = fa;
    $display("req cyc=%0d w=%0d addr=%h wdata=%h flush=%0d/%0d exp_hit=%0d", cyc, w, a, d, fa, fd_eff, hit);
    @(negedge clk);
    req_valid = 1'b0; flush_drv = 1'b0;
    req_write = 1'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0) begin
      check("rsp_timeout", rsp_q.size(), 0);
      rsp_q.delete();
      spi_q.delete();
    end
  endtask

  task automatic req(input logic w, input logic [15:0] a, input logic [7:0] d,
                     input logic fa, input logic fd);
    issue_req(w, a, d, fa, fd);
    wait_rsp();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_hit"}, rsp_hit, 0);
    check({tag, "_spi_start"}, spi_start, 0);
    check({tag, "_spi_write"}, spi_write, 0);
    check({tag, "_spi_address"}, spi_address, 0);
    check({tag, "_spi_wdata"}, spi_wdata, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'((i * 37) ^ (i >> 8) ^ 8'h5C);
    ref_mem[16'h1234] = 8'hA5;
    ref_mem[16'h0042] = 8'h77;
    clear_lines();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Cold read, then re-read
    s0 = spi_starts;
    req(1'b0, 16'h1234, 8'h00, 1'b0, 1'b0);
    check("cold_read_spi_count", spi_starts - s0, 1);
    s0 = spi_starts;
    req(1'b0, 16'h1234, 8'h00, 1'b0, 1'b0);
    check("reread_spi_count", spi_starts - s0, 0);

    // Write-through on a resident line, then uncached write
    s0 = spi_starts;
    req(1'b1, 16'h1234, 8'h5A, 1'b0, 1'b0);
    req(1'b0, 16'h1234, 8'h00, 1'b0, 1'b0);
    check("write_hit_spi_count", spi_starts - s0, 1);
    s0 = spi_starts;
    req(1'b1, 16'h2000, 8'h11, 1'b0, 1'b0);
    req(1'b0, 16'h2000, 8'h00, 1'b0, 1'b0);
    check("write_miss_spi_count", spi_starts - s0, 2);

    // Index conflict
    s0 = spi_starts;
    req(1'b0, 16'h0001, 8'h00, 1'b0, 1'b0);
    req(1'b0, 16'h0005, 8'h00, 1'b0, 1'b0);
    req(1'b0, 16'h0001, 8'h00, 1'b0, 1'b0);
    check("conflict_spi_count", spi_starts - s0, 3);

    // Flush coincident with fill, then with an accept
    s0 = spi_starts;
    req(1'b0, 16'h0042, 8'h00, 1'b0, 1'b1);
    req(1'b0, 16'h0042, 8'h00, 1'b0, 1'b0);
    check("flush_fill_spi_count", spi_starts - s0, 2);
    req(1'b0, 16'h0003, 8'h00, 1'b0, 1'b0);
    s0 = spi_starts;
    req(1'b0, 16'h0003, 8'h00, 1'b1, 1'b0);
    check("flush_accept_hit_spi_count", spi_starts - s0, 0);
    req(1'b0, 16'h0003, 8'h00, 1'b0, 1'b0);
    check("flush_accept_after_spi_count", spi_starts - s0, 1);

    // Randomised traffic over a small, conflicting address pool
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) a = 16'($urandom);
      else a = 16'($urandom_range(0, 15)) + ($urandom_range(0, 1) != 0 ? 16'h0100 : 16'h0000);
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        flush_drv = 1'b1;
        clear_lines();
        @(negedge clk);
        flush_drv = 1'b0;
      end
      req(($urandom_range(0, 3) == 0), a, 8'($urandom),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of a transaction
    req(1'b0, 16'h0007, 8'h00, 1'b0, 1'b0);
    req(1'b0, 16'h0007, 8'h00, 1'b0, 1'b0);
    issue_req(1'b0, 16'h0100, 8'h00, 1'b0, 1'b0);
    n = 0;
    while (!spi_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached_wait", spi_busy, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    rsp_q.delete();
    spi_q.delete();
    clear_lines();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_stray = 1'b1;
    @(negedge clk);
    done_stray = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_stray_done", req_ready, 1);
    s0 = spi_starts;
    req(1'b0, 16'h0007, 8'h00, 1'b0, 1'b0);
    check("post_reset_miss_spi_count", spi_starts - s0, 1);

    repeat (5) @(negedge clk);
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("spi_queue_drained", spi_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_mem_bridge.md
Name: spi_mem_bridge

Overview:
- CPU-side memory front end that sits directly upstream of the SPI memory controller.
- Accepts byte read/write requests over a valid/ready handshake and sequences them into single-transaction start pulses on the SPI controller.
- Read data is held in a small direct-mapped, write-through read cache, so repeated reads (instruction/operand fetch) avoid the ~65-cycle SPI round trip.

Parameters:
- ENTRIES, 4, number of cache lines; power of two, 2..16; IDX = log2(ENTRIES).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  bridge can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  16  byte address
- req_wdata  in  8  write data
- rsp_valid  out  1  single-cycle response strobe
- rsp_rdata  out  8  read data, valid with rsp_valid (0 for writes)
- rsp_hit  out  1  response served from cache, valid with rsp_valid
- flush  in  1  invalidate all cache lines
- spi_start  out  1  one-cycle start pulse to SPI controller
- spi_write  out  1  transaction direction to SPI controller
- spi_address  out  16  transaction address
- spi_wdata  out  8  write byte, drives the controller's databus
- spi_done  in  1  one-cycle completion pulse from SPI controller
- spi_rdata  in  8  read byte from SPI controller, valid when spi_done = 1

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; all valid bits = 0; request registers = 0.
  - Outputs: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_hit = 0, spi_start = 0, spi_write = 0, spi_address = 0, spi_wdata = 0.
- Cache line = {valid, tag = addr[15:IDX], data[7:0]}; index = addr[IDX-1:0].
- req_ready = 1 only in IDLE. Accept = req_valid & req_ready. On accept, write, addr and wdata are registered; the CPU may change its inputs afterwards.
- States:
  - IDLE: on accept, go to HIT_RSP if the request is a read and hits (valid & tag match). Otherwise go to ISSUE.
  - HIT_RSP: rsp_valid = 1, rsp_rdata = line data, rsp_hit = 1. Next state IDLE.
  - ISSUE: spi_start = 1 for exactly one cycle; spi_write/spi_address/spi_wdata come from the registered request. Next state WAIT.
  - WAIT: spi_write/spi_address/spi_wdata held stable. On spi_done:
    - read: install {1, tag, spi_rdata} into the line, capture spi_rdata.
    - write: if the line is valid and the tag matches, update its data to wdata. Write misses do not allocate.
    - Next state MISS_RSP.
  - MISS_RSP: rsp_valid = 1, rsp_hit = 0, rsp_rdata = captured byte (read) or 0 (write). Next state IDLE.
- Latency:
  - Read hit: accept at cycle T, rsp_valid at T+1, next accept possible at T+2.
  - Miss/write: spi_start at T+1; rsp_valid the cycle after spi_done.
- spi_start is never asserted outside ISSUE, so at most one SPI transaction is outstanding. spi_done outside WAIT is ignored.
- No response backpressure: the CPU must take rsp_valid when it is presented.
- Flush:
  - Clears all valid bits at the next edge; legal in any state.
  - Flush coincident with spi_done in WAIT: the fill is not installed, but the response still returns spi_rdata.
  - Flush coincident with an accept: the hit lookup uses pre-flush valid bits, so that request may still hit.
- Back-to-back requests: a write followed by a read of the same address returns the written byte if the line was resident, otherwise it refetches.
- Reset mid-transaction: the bridge returns to IDLE immediately. The SPI controller shares the reset and is also reset, so no stale spi_done is expected. Any stray spi_done is ignored in IDLE.

Test Plan:
- Cold read 0x1234, SPI model returns 0xA5 -> one spi_start with spi_write = 0, spi_address = 0x1234; rsp_valid the cycle after spi_done, rsp_rdata = 0xA5, rsp_hit = 0.
- Re-read 0x1234 -> no spi_start; rsp_valid at T+1, rsp_rdata = 0xA5, rsp_hit = 1.
- Write 0x5A to 0x1234, then read 0x1234 -> one SPI write (spi_wdata = 0x5A); the read hits with 0x5A. Write 0x11 to uncached 0x2000, then read 0x2000 -> the read misses and issues SPI.
- Conflict (ENTRIES = 4): read 0x0001, then 0x0005, then 0x0001 -> three SPI reads; the third is a miss.
- Flush asserted in the same cycle as spi_done for read 0x0042 (data 0x77) -> rsp_rdata = 0x77, and a subsequent read of 0x0042 misses.
- rst_n pulsed low during WAIT -> req_ready = 1 and all outputs at reset values immediately. A spurious spi_done afterwards produces no rsp_valid, and a read of a previously cached address misses.
